// File: rtl/spiker_input_loader.sv
// spiker_input_loader: double-buffered spike-word loader that presents one image
// to the core for N_STEPS valid/ready handshakes, with one idle cycle between steps.
module spiker_input_loader #(
   parameter int WIDTH    = 32,
   parameter int N_SPIKES = 784,
   parameter int N_WORDS  = 25,
   parameter int N_STEPS  = 15,
   parameter int IDX_W    = $clog2(N_WORDS),
   parameter int STEP_W   = $clog2(N_STEPS + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                wr_en_i,
   input  logic [IDX_W-1:0]    wr_idx_i,
   input  logic [WIDTH-1:0]    wr_data_i,
   input  logic                start_i,
   input  logic                clear_i,
   input  logic                core_ready_i,
   output logic [N_SPIKES-1:0] spikes_o,
   output logic                spikes_valid_o,
   output logic                busy_o,
   output logic                done_o,
   output logic [STEP_W-1:0]   step_o,
   output logic [N_WORDS-1:0]  loaded_o,
   output logic                err_o
);
   localparam int LAST_W = N_SPIKES - (N_WORDS - 1) * WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GAP, S_DONE} state_t;

   state_t              r_state, w_next;
   logic [N_SPIKES-1:0] w_load, r_shadow;
   logic [N_WORDS-1:0]  r_loaded, w_wr_mask;
   logic [STEP_W-1:0]   r_step;
   logic                r_err, w_idx_ok, w_wr, w_idle, w_start, w_hs, w_last;

   assign w_idx_ok  = {1'b0, wr_idx_i} < (IDX_W + 1)'(N_WORDS);
   assign w_wr      = wr_en_i && w_idx_ok;
   assign w_wr_mask = w_wr ? N_WORDS'(1) << wr_idx_i : '0;
   assign w_idle    = r_state == S_IDLE;
   assign w_start   = start_i && w_idle && &r_loaded;
   assign w_hs      = r_state == S_PRESENT && core_ready_i;
   assign w_last    = r_step == STEP_W'(N_STEPS - 1);

   // The last word is narrower, so its unused upper data bits never get a flop.
   genvar g;
   generate
      for (g = 0; g < N_WORDS; g++) begin : g_word
         localparam int W = (g == N_WORDS - 1) ? LAST_W : WIDTH;
         logic [W-1:0] r_word;
         always_ff @(posedge clk_i or negedge rst_ni)
            if (!rst_ni) r_word <= '0;
            else if (clear_i) r_word <= '0;
            else if (w_wr && wr_idx_i == IDX_W'(g)) r_word <= wr_data_i[W-1:0];
         assign w_load[g*WIDTH +: W] = r_word;
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_shadow <= '0;
         r_loaded <= '0;
         r_step   <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (clear_i) begin
            r_shadow <= '0;
            r_loaded <= '0;
            r_step   <= '0;
            r_err    <= 1'b0;
         end else begin
            if (w_start) r_shadow <= w_load;
            r_loaded <= w_start ? w_wr_mask : r_loaded | w_wr_mask;
            r_step   <= w_start ? '0 : w_hs ? r_step + STEP_W'(1) : r_step;
            if ((wr_en_i && !w_idx_ok) || (start_i && w_idle && !(&r_loaded))) r_err <= 1'b1;
         end
      end

   always_comb begin
      w_next = r_state;
      if (clear_i) w_next = S_IDLE;
      else
         case (r_state)
            S_IDLE:    w_next = w_start ? S_PRESENT : S_IDLE;
            S_PRESENT: w_next = !w_hs ? S_PRESENT : w_last ? S_DONE : S_GAP;
            S_GAP:     w_next = S_PRESENT;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
         endcase
   end

   assign spikes_o       = r_shadow;
   assign spikes_valid_o = r_state == S_PRESENT;
   assign busy_o         = !w_idle;
   assign done_o         = r_state == S_DONE;
   assign step_o         = r_step;
   assign loaded_o       = r_loaded;
   assign err_o          = r_err;
endmodule
